mux_rr_arbiter: RTL

//  Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters.
//  It generates the mux select s[1:0] and a one-hot grant, and registers the selected bit as Y.

---
 rtl/mux_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux between four requesters.
// Produces a registered one-hot grant and mux select, and a registered copy
// of the selected data bit. A busy owner is rotated out after MAX_HOLD
// consecutive grant cycles whenever someone else is waiting.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] I,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       Y,
  output logic       valid
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_s;
  logic             r_y;
  logic             r_valid;

  state_t           w_state_next;
  logic [1:0]       w_ptr_next;
  logic [CNT_W-1:0] w_hold_next;
  logic [3:0]       w_gnt_next;
  logic [1:0]       w_s_next;
  logic             w_y_next;
  logic             w_valid_next;

  logic [1:0]       w_owner_nxt;
  logic [2:0]       w_pick_ptr;
  logic [2:0]       w_pick_nxt;
  logic [3:0]       w_others;

  // First set request at or after 'start' (mod 4); returns {found, index}.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk offsets from farthest to nearest so the nearest set request wins.
    for (int off = 3; off >= 0; off--) begin
      idx = start + 2'(off);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_owner_nxt = r_s + 2'd1;
  assign w_pick_ptr  = rr_search(req, r_ptr);
  assign w_pick_nxt  = rr_search(req, w_owner_nxt);
  // While granting, r_gnt is onehot(owner), so this masks the owner out.
  assign w_others    = req & ~r_gnt;

  // State register: all arbiter and datapath state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
      r_gnt      <= 4'b0000;
      r_s        <= 2'd0;
      r_y        <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_hold_cnt <= w_hold_next;
      r_gnt      <= w_gnt_next;
      r_s        <= w_s_next;
      r_y        <= w_y_next;
      r_valid    <= w_valid_next;
    end
  end

  // Next-state logic: pick a new owner, rotate on release or hold expiry.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_hold_next  = r_hold_cnt;
    w_gnt_next   = r_gnt;
    w_s_next     = r_s;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_ptr[2]) begin
          w_gnt_next   = 4'b0001 << w_pick_ptr[1:0];
          w_s_next     = w_pick_ptr[1:0];
          w_hold_next  = ONE_C;
          w_state_next = ST_GRANT;
        end else begin
          w_gnt_next = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (!req[r_s]) begin
          // Owner released: hand straight over to the next waiter, if any.
          w_ptr_next = w_owner_nxt;
          if (w_pick_nxt[2]) begin
            w_gnt_next  = 4'b0001 << w_pick_nxt[1:0];
            w_s_next    = w_pick_nxt[1:0];
            w_hold_next = ONE_C;
          end else begin
            w_gnt_next   = 4'b0000;
            w_hold_next  = '0;
            w_state_next = ST_IDLE;
          end
        end else if ((r_hold_cnt == MAX_HOLD_C) && (|w_others)) begin
          // Hold budget spent and someone is waiting: force rotation.
          w_ptr_next  = w_owner_nxt;
          w_gnt_next  = 4'b0001 << w_pick_nxt[1:0];
          w_s_next    = w_pick_nxt[1:0];
          w_hold_next = ONE_C;
        end else if (r_hold_cnt < MAX_HOLD_C) begin
          w_hold_next = r_hold_cnt + ONE_C;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
  end

  // Output logic: datapath stage lags the grant by one cycle.
  always_comb begin
    w_y_next     = 1'b0;
    w_valid_next = |r_gnt;
    if (|r_gnt) w_y_next = I[r_s];
  end

  assign gnt   = r_gnt;
  assign s     = r_s;
  assign Y     = r_y;
  assign valid = r_valid;

endmodule
